// File: rtl/result_demux_router_if.sv
// result_demux_router_if: the producer port and both consumer channels of result_demux_router
// grouped into one bundle. The router connects through the slave modport; the master modport
// is the environment's view (producer plus both consumers).
interface result_demux_router_if #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CNT_WIDTH = 16
);
   // producer side
   logic                 In_Valid;
   logic                 In_Ready;
   logic                 Selector;
   logic [WIDTH-1:0]     Data_In;
   // channel A (accumulator side)
   logic                 A_Valid;
   logic                 A_Ready;
   logic [WIDTH-1:0]     A_Data;
   // channel B (register-file / memory side)
   logic                 B_Valid;
   logic                 B_Ready;
   logic [WIDTH-1:0]     B_Data;
   // delivery counters
   logic [CNT_WIDTH-1:0] A_Count;
   logic [CNT_WIDTH-1:0] B_Count;

   // router view
   modport slave (
      input  In_Valid, Selector, Data_In, A_Ready, B_Ready,
      output In_Ready, A_Valid, A_Data, B_Valid, B_Data, A_Count, B_Count
   );

   // environment view: producer plus both consumers
   modport master (
      output In_Valid, Selector, Data_In, A_Ready, B_Ready,
      input  In_Ready, A_Valid, A_Data, B_Valid, B_Data, A_Count, B_Count
   );
endinterface

// File: rtl/result_demux_router.sv
// result_demux_router: registered 1-to-2 demultiplexer that steers the result word into one of
// two single-entry channel buffers (A = accumulator side, B = register-file/memory side).
// Optional feature macro: ROUTE_COUNT_EN builds per-channel delivery counters; when it is not
// defined, A_Count/B_Count are tied to zero.
module result_demux_router #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                   CLK,
   input  logic                   Reset_n,
   input  logic                   Flush,
   result_demux_router_if.slave   bus
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } chan_state_e;

   chan_state_e      a_state_q, a_state_d;
   chan_state_e      b_state_q, b_state_d;
   logic [WIDTH-1:0] a_data_q,  a_data_d;
   logic [WIDTH-1:0] b_data_q,  b_data_d;

   logic a_room_c;
   logic b_room_c;
   logic in_ready_c;
   logic accept_c;
   logic load_a_c;
   logic load_b_c;
   logic drain_a_c;
   logic drain_b_c;

   // Input handshake: only the selected channel may stall the producer.
   always_comb begin
      a_room_c   = (a_state_q == ST_EMPTY) | bus.A_Ready;
      b_room_c   = (b_state_q == ST_EMPTY) | bus.B_Ready;
      in_ready_c = ~Flush & (bus.Selector ? b_room_c : a_room_c);
      accept_c   = bus.In_Valid & in_ready_c;
      load_a_c   = accept_c & ~bus.Selector;
      load_b_c   = accept_c &  bus.Selector;
      drain_a_c  = (a_state_q == ST_FULL) & bus.A_Ready;
      drain_b_c  = (b_state_q == ST_FULL) & bus.B_Ready;
   end

   // Channel A next state: load wins over drain, flush empties the buffer.
   always_comb begin
      a_state_d = a_state_q;
      a_data_d  = a_data_q;
      if (Flush) begin
         a_state_d = ST_EMPTY;
      end else begin
         unique case (a_state_q)
            ST_EMPTY: if (load_a_c)                  a_state_d = ST_FULL;
            ST_FULL:  if (drain_a_c && !load_a_c)    a_state_d = ST_EMPTY;
         endcase
      end
      if (load_a_c) begin
         a_data_d = bus.Data_In;
      end
   end

   // Channel B next state: load wins over drain, flush empties the buffer.
   always_comb begin
      b_state_d = b_state_q;
      b_data_d  = b_data_q;
      if (Flush) begin
         b_state_d = ST_EMPTY;
      end else begin
         unique case (b_state_q)
            ST_EMPTY: if (load_b_c)                  b_state_d = ST_FULL;
            ST_FULL:  if (drain_b_c && !load_b_c)    b_state_d = ST_EMPTY;
         endcase
      end
      if (load_b_c) begin
         b_data_d = bus.Data_In;
      end
   end

   // Channel state and data registers; reset discards any buffered word.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         a_state_q <= ST_EMPTY;
         b_state_q <= ST_EMPTY;
         a_data_q  <= '0;
         b_data_q  <= '0;
      end else begin
         a_state_q <= a_state_d;
         b_state_q <= b_state_d;
         a_data_q  <= a_data_d;
         b_data_q  <= b_data_d;
      end
   end

   assign bus.In_Ready = in_ready_c;
   assign bus.A_Valid  = (a_state_q == ST_FULL);
   assign bus.B_Valid  = (b_state_q == ST_FULL);
   assign bus.A_Data   = a_data_q;
   assign bus.B_Data   = b_data_q;

`ifdef ROUTE_COUNT_EN
   logic [CNT_WIDTH-1:0] a_cnt_q, a_cnt_d;
   logic [CNT_WIDTH-1:0] b_cnt_q, b_cnt_d;

   // Delivery counters: one step per drain, wrap naturally, untouched by flush.
   always_comb begin
      a_cnt_d = a_cnt_q;
      b_cnt_d = b_cnt_q;
      if (drain_a_c) a_cnt_d = a_cnt_q + CNT_WIDTH'(1);
      if (drain_b_c) b_cnt_d = b_cnt_q + CNT_WIDTH'(1);
   end

   // Counter registers.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         a_cnt_q <= '0;
         b_cnt_q <= '0;
      end else begin
         a_cnt_q <= a_cnt_d;
         b_cnt_q <= b_cnt_d;
      end
   end

   assign bus.A_Count = a_cnt_q;
   assign bus.B_Count = b_cnt_q;
`else
   assign bus.A_Count = CNT_WIDTH'(0);
   assign bus.B_Count = CNT_WIDTH'(0);
`endif

endmodule

// File: doc/result_demux_router.md
# result_demux_router

Registered 1-to-2 demultiplexer for the accumulator processor datapath; the steering counterpart of the 2:1 operand select mux. Accepts one 16-bit word per cycle from a single producer (ALU/write-back result) under valid/ready handshake. Routes each word by a 1-bit selector into one of two single-entry output buffers, channel A (accumulator side) or channel B (register-file/memory side). Each channel then presents the word to its consumer under its own valid/ready handshake.

## Interface
- WIDTH, 16, data width of every data port
- CNT_WIDTH, 16, width of per-channel transfer counters (used only with the counter feature)

- CLK  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- Flush  input  1  synchronous clear of both channel buffers
- In_Valid  input  1  producer has a word
- In_Ready  output  1  router accepts the word this cycle
- Selector  input  1  0 = route to channel A, 1 = route to channel B; sampled with In_Valid
- Data_In  input  WIDTH  word to route
- A_Valid  output  1  channel A buffer holds a word
- A_Ready  input  1  channel A consumer takes the word
- A_Data  output  WIDTH  channel A word
- B_Valid  output  1  channel B buffer holds a word
- B_Ready  input  1  channel B consumer takes the word
- B_Data  output  WIDTH  channel B word
- A_Count  output  CNT_WIDTH  words delivered on A (ROUTE_COUNT_EN only)
- B_Count  output  CNT_WIDTH  words delivered on B (ROUTE_COUNT_EN only)

## Operation
- Each channel is a two-state FSM: EMPTY (Valid=0) and FULL (Valid=1). Data register and Valid are registered outputs.
- Accept condition: In_Valid & In_Ready.
- In_Ready = ~Flush & (selected channel EMPTY | selected channel Ready). It depends combinationally on Selector and the selected channel's Ready only. The unselected channel never stalls the input.
- On accept, the word loads into the selected channel's data register, and that channel goes to or stays FULL.
- Drain condition per channel: Valid & Ready. If there is no load the same cycle, the channel goes FULL→EMPTY. The data register holds its last value and is not cleared.
- Simultaneous drain and load on the same channel: the old word is delivered and the new word is loaded. The channel stays FULL, which gives full throughput.
- Simultaneous load on one channel and drain on the other: each channel is handled independently.
- Flush=1: both channels go to EMPTY next edge. Data registers are unchanged. No accept occurs that cycle, since In_Ready=0. Drains on that edge still count as delivered.
- Words on a channel are delivered in acceptance order. There is no ordering guarantee between channels.
- Valid is never deasserted without a drain or Flush. Data is stable while Valid & ~Ready.

## Timing
- Reset (Reset_n=0, asynchronous): A_Valid=B_Valid=0, A_Data=B_Data=0, A_Count=B_Count=0. In_Ready follows its equation, so it is 1 while Flush=0.
- Reset asserted mid-transfer discards any buffered word. The first edge after Reset_n rises may accept.
- Latency: a word accepted at edge N appears on X_Data with X_Valid=1 after edge N. The earliest drain is edge N+1.
- Throughput: 1 word/cycle sustained into one channel when its consumer holds Ready=1. 1 word/cycle alternating between channels.
- No combinational path from Data_In to any output.

## Configuration
- ROUTE_COUNT_EN defined:
  - A_Count/B_Count increment by 1 on each drain of their channel.
  - Counters wrap from all-ones to 0 and reset to 0.
  - Flush does not clear them.
- ROUTE_COUNT_EN undefined:
  - Counter registers are not built.
  - A_Count/B_Count are driven constant 0.

## Test plan
- Route: after reset, A_Ready=B_Ready=1, Selector=0, Data_In=16'h1234, In_Valid for one cycle → A_Valid=1 with A_Data=16'h1234 for exactly one cycle after the accept edge. B_Valid stays 0.
- Backpressure: A_Ready=0, send 16'hAAAA then 16'hBBBB to A.
  - In_Ready drops after the first accept, and A_Data holds 16'hAAAA.
  - Raise A_Ready → 16'hAAAA delivered, 16'hBBBB accepted the same edge, then delivered.
- Independence: channel A FULL with A_Ready=0, Selector=1, Data_In=16'h00FF → In_Ready=1, and B_Data=16'h00FF is delivered while A still holds its word.
- Streaming: A_Ready=1, Selector=0, 8 consecutive words 0..7 → 8 deliveries on 8 consecutive cycles in order. With ROUTE_COUNT_EN, A_Count=8.
- Flush: both channels FULL, both Ready=0, Flush=1 with In_Valid=1 → In_Ready=0, both Valid=0 next cycle, and no word accepted.
- Async reset mid-operation: Reset_n low between edges while channel B is FULL → B_Valid=0, B_Data=0, and B_Count=0 immediately, without waiting for a clock edge.
